seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Downstream display stage for the 4-bit ALU / 7-segment decoder. It accepts a 16-bit result word (four hex nibbles) through a ready/load handshake and time-multiplexes it onto one shared set of segment lines with one-hot digit selects. New values are applied only at frame boundaries, so a single scan never shows a mix of old and new values. It also provides enable blanking and optional leading-zero suppression.

## Interface
- `CLK_DIV`, default 1000: clock cycles per digit slot. Legal range is 2..65535.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `load`  in  1  request to capture `value_in`. It takes effect only when `ready`=1.
- `value_in`  in  16  value to display. Nibble k drives digit k; digit 0 is the least significant nibble.
- `enable`  in  1  display enable. When 0, all segments and digit selects are forced off.
- `blank_lz`  in  1  leading-zero blanking enable.
- `ready`  out  1  high when the pending register is free and a load will be accepted.
- `seg`  out  7  segment bits {a,b,c,d,e,f,g}, active-high.
- `dig_sel`  out  4  one-hot digit select, active-high; bit k selects digit k.
- `frame_done`  out  1  one-cycle pulse after each full 4-digit scan.

## Operation
- **Prescaler:** `pcnt` counts 0..CLK_DIV-1. The `tick` condition is `pcnt`==CLK_DIV-1; on the next edge `pcnt` returns to 0.
- **Digit index:** 2-bit `idx` advances on `tick`. The sequence 0→1→2→3→0 wraps modulo 4.
- **Wrap event:** `tick` while `idx`==3.
- **Registers:** `disp_reg` (16 bits) holds the value on display. `pend_reg` (16 bits) holds a captured value, and `pend_v` marks it valid. `ready` = !`pend_v`, and is a registered output.
- **Load handshake:**
  - `load`=1 and `ready`=1 at an edge: `pend_reg` ← `value_in` and `pend_v` ← 1, so `ready`=0 from the next cycle.
  - `load` while `ready`=0 is ignored, with no overwrite.
- **Frame commit:** on a wrap event with `pend_v`=1, `disp_reg` ← `pend_reg` and `pend_v` ← 0. `ready` returns to 1 the next cycle.
- **Simultaneous load and wrap with `ready`=1:** the value goes to `pend_reg` only. It commits at the following wrap and is never bypassed directly to `disp_reg`.
- **Decode table** (nibble → `seg`), same encoding as the ALU decoder:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111
- **Leading-zero blanking:** with `blank_lz`=1, digit k (k≥1) is blank when every nibble of `disp_reg` from k up to 3 is zero. Digit 0 is never blanked, so a value of 0 displays "0". A blank slot drives `seg`=0 and `dig_sel`=0.
- **Enable:** with `enable`=0, `seg`=0 and `dig_sel`=0. The prescaler, `idx`, handshake and `frame_done` keep running regardless of `enable`.
- **Output path:** `seg` and `dig_sel` are registered, decoded from the current `idx`, `disp_reg`, `enable` and `blank_lz`.

## Timing
- **Reset values:** `pcnt`=0, `idx`=0, `disp_reg`=0, `pend_reg`=0, `pend_v`=0, `ready`=1, `seg`=0000000, `dig_sel`=0000, `frame_done`=0.
- **Output latency:** `seg` and `dig_sel` reflect `idx` one cycle after the edge that updates it. In the first cycle after reset release with `enable`=1, outputs are `seg`=1111110 and `dig_sel`=0001.
- **Slot timing:**
  - Each digit slot lasts exactly CLK_DIV cycles at the outputs.
  - One frame lasts 4×CLK_DIV cycles.
- **`frame_done`:** registered, high for exactly one cycle immediately following the wrap edge. It pulses whether or not a commit occurred.
- **Display latency:** a committed value appears in the first slot of the new frame (digit 0), one cycle after the wrap edge.
- **Load-to-display:** worst case is 4×CLK_DIV+1 cycles.
- **Mid-operation reset:** `rst` dominates every other input at the same edge. Pending data is discarded, `disp_reg` is cleared and `ready`=1 after that edge.
- **Asynchronous inputs:** `enable` and `blank_lz` changes take effect on outputs one cycle after they are sampled, mid-slot if necessary.

## Test plan
Run with CLK_DIV=4, giving a frame length of 16 cycles.
1. **Reset, then idle with `enable`=1, `blank_lz`=0** → `dig_sel` cycles 0001, 0010, 0100, 1000, 4 cycles each. `seg`=1111110 throughout. `frame_done` pulses every 16 cycles. `ready`=1.
2. **Load 0x1A2F mid-frame** → `ready`=0 until the wrap. The next frame shows digit0=1000111 (F), digit1=1101101 (2), digit2=1110111 (A), digit3=0110000 (1). `ready`=1 the cycle after the wrap.
3. **Second load while `ready`=0** (0x1111 pending, then 0x2222 offered) → 0x2222 is ignored and the display shows 0x1111.
4. **`blank_lz`=1, load 0x0040** → digit1=0110011 (4), digit0=1111110 (0). Digits 2 and 3 have `dig_sel`=0000 and `seg`=0. Loading 0x0000 shows only digit0 "0".
5. **Toggle `enable`=0 for 10 cycles** → `seg`=0 and `dig_sel`=0 one cycle later. `frame_done` cadence is unchanged, and scan phase resumes intact.
6. **Assert `rst` one cycle during a pending load** → after the edge, `ready`=1. The next output cycle shows `seg`=1111110 and `dig_sel`=0001; the pending value never appears.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with frame-aligned value commit,
// enable blanking and optional leading-zero suppression.
module seg7_scan_driver #(
    parameter int unsigned CLK_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic        enable,
    input  logic        blank_lz,
    output logic        ready,
    output logic [6:0]  seg,
    output logic [3:0]  dig_sel,
    output logic        frame_done
);
    localparam int unsigned PCNT_W = 16;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned VAL_W  = 16;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIG_W  = 4;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(CLK_DIV - 1);

    logic [PCNT_W-1:0] pcnt;
    logic [IDX_W-1:0]  idx;
    logic [VAL_W-1:0]  disp_reg;
    logic [VAL_W-1:0]  pend_reg;
    logic              pend_v;

    logic              tick_c;
    logic              wrap_c;
    logic              accept_c;
    logic              commit_c;
    logic [3:0]        nib_c;
    logic              lz_c;
    logic              show_c;
    logic [SEG_W-1:0]  seg_nxt_c;
    logic [DIG_W-1:0]  dig_nxt_c;

    function automatic logic [SEG_W-1:0] decode(input logic [3:0] nib);
        logic [SEG_W-1:0] s;
        case (nib)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Scan events, handshake qualifiers and next-slot output decode
    always_comb begin
        tick_c    = 1'b0;
        wrap_c    = 1'b0;
        accept_c  = 1'b0;
        commit_c  = 1'b0;
        nib_c     = 4'h0;
        lz_c      = 1'b0;
        show_c    = 1'b0;
        seg_nxt_c = '0;
        dig_nxt_c = '0;

        tick_c   = (pcnt == PCNT_MAX);
        wrap_c   = tick_c && (idx == IDX_W'(3));
        accept_c = load && ready;
        commit_c = wrap_c && pend_v;

        // A slot is a leading zero when it and every higher nibble are zero
        case (idx)
            2'd0: begin nib_c = disp_reg[3:0];   lz_c = 1'b0;                     end
            2'd1: begin nib_c = disp_reg[7:4];   lz_c = (disp_reg[15:4]  == '0); end
            2'd2: begin nib_c = disp_reg[11:8];  lz_c = (disp_reg[15:8]  == '0); end
            default: begin nib_c = disp_reg[15:12]; lz_c = (disp_reg[15:12] == '0); end
        endcase

        show_c = enable && !(blank_lz && lz_c);
        if (show_c) begin
            seg_nxt_c = decode(nib_c);
            dig_nxt_c = DIG_W'(4'b0001 << idx);
        end
    end

    // Prescaler, digit index, pending/display registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt       <= '0;
            idx        <= '0;
            disp_reg   <= '0;
            pend_reg   <= '0;
            pend_v     <= 1'b0;
            ready      <= 1'b1;
            seg        <= '0;
            dig_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            pcnt <= tick_c ? '0 : pcnt + PCNT_W'(1);
            if (tick_c) begin
                idx <= idx + IDX_W'(1);
            end

            // accept implies pend_v is clear, so it can never coincide with a commit
            if (accept_c) begin
                pend_reg <= value_in;
                pend_v   <= 1'b1;
                ready    <= 1'b0;
            end else if (commit_c) begin
                disp_reg <= pend_reg;
                pend_v   <= 1'b0;
                ready    <= 1'b1;
            end

            frame_done <= wrap_c;
            seg        <= seg_nxt_c;
            dig_sel    <= dig_nxt_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a time-based reference model predicts
// every output cycle; a separate monitor compares on the falling edge.
module tb_seg7_scan_driver;
    localparam int unsigned D = 4;
    localparam int unsigned FRAME = 4 * D;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value_in;
    logic        enable;
    logic        blank_lz;
    logic        ready;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic        frame_done;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    seg7_scan_driver #(.CLK_DIV(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value_in   (value_in),
        .enable     (enable),
        .blank_lz   (blank_lz),
        .ready      (ready),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: outputs as a function of time since reset and the
    // value history; pushes one expectation per clock edge.
    initial begin
        int unsigned mn;
        int unsigned slot;
        logic        wrap;
        logic        blank;
        logic [15:0] m_disp;
        logic [15:0] m_pend;
        logic        m_pv;
        logic [3:0]  nib;
        exp_t        e;
        mn = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
        forever begin
            @(posedge clk);
            e = '0;
            if (rst) begin
                mn = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
                e.rdy = 1'b1;
            end else begin
                mn++;
                slot  = ((mn - 1) / D) % 4;
                wrap  = (mn % FRAME) == 0;
                nib   = 4'(m_disp >> (4 * slot));
                blank = blank_lz && (slot != 0) && ((m_disp >> (4 * slot)) == 16'h0);
                if (enable && !blank) begin
                    e.seg = seg_tab[nib];
                    e.dig = 4'(1 << slot);
                end
                e.fd = wrap;
                if (load && !m_pv) begin
                    m_pend = value_in;
                    m_pv   = 1'b1;
                end else if (wrap && m_pv) begin
                    m_disp = m_pend;
                    m_pv   = 1'b0;
                end
                e.rdy = !m_pv;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: pops one expectation per presented output cycle
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("seg",        32'(seg),        32'(e.seg));
                check("dig_sel",    32'(dig_sel),    32'(e.dig));
                check("frame_done", 32'(frame_done), 32'(e.fd));
                check("ready",      32'(ready),      32'(e.rdy));
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic offer(input logic [15:0] v);
        load     = 1'b1;
        value_in = v;
        step(1);
        load     = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        rst = 1'b1; load = 1'b0; value_in = '0; enable = 1'b1; blank_lz = 1'b0;
        step(3);
        rst = 1'b0;

        // idle scan of zero
        step(2 * FRAME);
        // mid-frame load
        step(5);
        offer(16'h1A2F);
        step(2 * FRAME);
        // second offer while pending is dropped
        offer(16'h1111);
        offer(16'h2222);
        step(2 * FRAME);
        // leading-zero blanking
        blank_lz = 1'b1;
        offer(16'h0040);
        step(2 * FRAME);
        offer(16'h0000);
        step(2 * FRAME);
        blank_lz = 1'b0;
        // enable off for 10 cycles, mid-slot
        step(3);
        enable = 1'b0;
        step(10);
        enable = 1'b1;
        step(FRAME + 4);
        // reset while a load is pending
        offer(16'hBEEF);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2 * FRAME);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            load = ($urandom_range(0, 3) == 0);
            v = 16'($urandom);
            value_in = v >> (4 * $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            rst = ($urandom_range(0, 299) == 0);
            step(1);
        end
        load = 1'b0; rst = 1'b0; enable = 1'b1;
        step(4);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
